// File: rtl/onehot_decoder_seq_pkg.sv
// Shared types and constants for the sequenced one-hot decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package onehot_decoder_pkg;

   // Controller state; 2-bit encoding with one unused code.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_SCAN = 2'd2
   } state_t;

   // Scan direction values carried on dir.
   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/onehot_decoder_seq_if.sv
// Command/status bundle between control logic and the sequenced decoder.
// Latency: n/a (wires only).
// Backpressure: none; commands are sampled every clock edge.
// Ports: master drives clear/load/scan_start/step/dir/sel and observes
//        y/idx/valid/wrap; slave is the decoder side.
interface onehot_decoder_seq_if #(
   parameter int SEL_W = 4
);
   localparam int OUT_W = 2 ** SEL_W;

   logic             clear;
   logic             load;
   logic             scan_start;
   logic             step;
   logic             dir;
   logic [SEL_W-1:0] sel;
   logic [OUT_W-1:0] y;
   logic [SEL_W-1:0] idx;
   logic             valid;
   logic             wrap;

   modport master (
      output clear, load, scan_start, step, dir, sel,
      input  y, idx, valid, wrap
   );

   modport slave (
      input  clear, load, scan_start, step, dir, sel,
      output y, idx, valid, wrap
   );

endinterface

// File: rtl/onehot_decoder_seq_decoder.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder with enable.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: en gates all outputs low; a is the index; d has bit a set when en=1.
module decoder_n_to_2n #(
   parameter int SEL_W = 4
) (
   input  logic                  en,
   input  logic [SEL_W-1:0]      a,
   output logic [2**SEL_W-1:0]   d
);

   always_comb begin
      d = '0;
      if (en) begin
         d[a] = 1'b1;
      end
   end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with hold/clear FSM and auto-stepping scan.
// Latency: 1 cycle from command to y/idx/valid/wrap, all updated together.
// Backpressure: none; every command is accepted on the edge it is seen.
// Ports: clk rising edge; rst async active-high; bus carries commands
//        (clear > load > scan_start > step) and registered status outputs.
module onehot_decoder_seq
   import onehot_decoder_pkg::*;
#(
   parameter int SEL_W     = 4,
   parameter bit OUT_INV   = 1'b0,
   parameter int RESET_IDX = 0
) (
   input  logic                clk,
   input  logic                rst,
   onehot_decoder_seq_if.slave bus
);

   localparam int               OUT_W   = 2 ** SEL_W;
   localparam logic [SEL_W-1:0] IDX_RST = SEL_W'(RESET_IDX);
   localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(OUT_W - 1);
   localparam logic [SEL_W-1:0] IDX_ONE = SEL_W'(1);
   // XOR mask turning the active-high decode into the output polarity.
   localparam logic [OUT_W-1:0] Y_MASK  = {OUT_W{OUT_INV}};

   state_t           state_q, state_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic             wrap_q, wrap_d;
   logic             valid_q, valid_d;
   logic [OUT_W-1:0] y_q, y_d;
   logic [OUT_W-1:0] dec_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wrap_d  = 1'b0;

      case (state_q)
         ST_IDLE, ST_HOLD, ST_SCAN: begin
            if (bus.clear) begin
               state_d = ST_IDLE;
            end else if (bus.load) begin
               idx_d   = bus.sel;
               state_d = ST_HOLD;
            end else if (bus.scan_start) begin
               // Reload never flags a wrap, even if sel crosses the boundary.
               idx_d   = bus.sel;
               state_d = ST_SCAN;
            end else if (bus.step && (state_q == ST_SCAN)) begin
               if (bus.dir == DIR_DN) begin
                  idx_d  = idx_q - IDX_ONE;
                  wrap_d = (idx_q == '0);
               end else begin
                  idx_d  = idx_q + IDX_ONE;
                  wrap_d = (idx_q == IDX_MAX);
               end
            end
         end
         default: begin
            // Unused encoding: fall back to a safe, deasserted state.
            state_d = ST_IDLE;
         end
      endcase
   end

   assign valid_d = (state_d != ST_IDLE);

   // Decode from next-state values so y lines up with idx/valid in the same cycle.
   decoder_n_to_2n #(
      .SEL_W (SEL_W)
   ) u_dec (
      .en (valid_d),
      .a  (idx_d),
      .d  (dec_d)
   );

   assign y_d = dec_d ^ Y_MASK;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= IDX_RST;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
         y_q     <= Y_MASK;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
         y_q     <= y_d;
      end
   end

   assign bus.y     = y_q;
   assign bus.idx   = idx_q;
   assign bus.valid = valid_q;
   assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed self-checking bench for onehot_decoder_seq.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_onehot_decoder_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   onehot_decoder_seq_if #(.SEL_W(4)) b4  ();
   onehot_decoder_seq_if #(.SEL_W(4)) b4i ();
   onehot_decoder_seq_if #(.SEL_W(2)) b2  ();
   onehot_decoder_seq_if #(.SEL_W(5)) b5  ();

   onehot_decoder_seq #(.SEL_W(4), .OUT_INV(1'b0), .RESET_IDX(0)) u_dut4 (
      .clk (clk), .rst (rst), .bus (b4)
   );
   onehot_decoder_seq #(.SEL_W(4), .OUT_INV(1'b1), .RESET_IDX(3)) u_dut4i (
      .clk (clk), .rst (rst), .bus (b4i)
   );
   onehot_decoder_seq #(.SEL_W(2), .OUT_INV(1'b0), .RESET_IDX(0)) u_dut2 (
      .clk (clk), .rst (rst), .bus (b2)
   );
   onehot_decoder_seq #(.SEL_W(5), .OUT_INV(1'b0), .RESET_IDX(0)) u_dut5 (
      .clk (clk), .rst (rst), .bus (b5)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      b4.clear = 0;  b4.load = 0;  b4.scan_start = 0;  b4.step = 0;  b4.dir = 0;  b4.sel = '0;
      b4i.clear = 0; b4i.load = 0; b4i.scan_start = 0; b4i.step = 0; b4i.dir = 0; b4i.sel = '0;
      b2.clear = 0;  b2.load = 0;  b2.scan_start = 0;  b2.step = 0;  b2.dir = 0;  b2.sel = '0;
      b5.clear = 0;  b5.load = 0;  b5.scan_start = 0;  b5.step = 0;  b5.dir = 0;  b5.sel = '0;
   endtask

   task automatic test_reset();
      idle_all();
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({b4.y, b4.idx, b4.valid, b4.wrap} !== {16'h0000, 4'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_plain got y=%h idx=%0d v=%b w=%b exp y=0000 idx=0 v=0 w=0", b4.y, b4.idx, b4.valid, b4.wrap);
      end
      checks++;
      if ({b4i.y, b4i.idx, b4i.valid, b4i.wrap} !== {16'hFFFF, 4'd3, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_inv got y=%h idx=%0d v=%b w=%b exp y=ffff idx=3 v=0 w=0", b4i.y, b4i.idx, b4i.valid, b4i.wrap);
      end
      tick();
      @(negedge clk) rst = 1'b0;
      tick();
      checks++;
      if ({b4.y, b4.idx, b4.valid, b4.wrap} !== {16'h0000, 4'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL idle_after_release got y=%h idx=%0d v=%b w=%b exp y=0000 idx=0 v=0 w=0", b4.y, b4.idx, b4.valid, b4.wrap);
      end
      // step in IDLE does nothing
      b4.step = 1;
      tick();
      b4.step = 0;
      checks++;
      if ({b4.y, b4.idx, b4.valid} !== {16'h0000, 4'd0, 1'b0}) begin
         failures++;
         $display("FAIL idle_step got y=%h idx=%0d v=%b exp y=0000 idx=0 v=0", b4.y, b4.idx, b4.valid);
      end
   endtask

   task automatic test_load();
      b4.load = 1;  b4.sel = 4'd5;
      b4i.load = 1; b4i.sel = 4'd5;
      tick();
      checks++;
      if ({b4.y, b4.idx, b4.valid, b4.wrap} !== {16'h0020, 4'd5, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL load5 got y=%h idx=%0d v=%b w=%b exp y=0020 idx=5 v=1 w=0", b4.y, b4.idx, b4.valid, b4.wrap);
      end
      checks++;
      if ({b4i.y, b4i.idx, b4i.valid} !== {16'hFFDF, 4'd5, 1'b1}) begin
         failures++;
         $display("FAIL load5_inv got y=%h idx=%0d v=%b exp y=ffdf idx=5 v=1", b4i.y, b4i.idx, b4i.valid);
      end
      b4i.load = 0;
      b4.sel = 4'd15;
      tick();
      checks++;
      if ({b4.y, b4.idx, b4.valid} !== {16'h8000, 4'd15, 1'b1}) begin
         failures++;
         $display("FAIL load15 got y=%h idx=%0d v=%b exp y=8000 idx=15 v=1", b4.y, b4.idx, b4.valid);
      end
      b4.load = 0;
      b4.step = 1;
      tick();
      b4.step = 0;
      checks++;
      if ({b4.y, b4.idx, b4.valid} !== {16'h8000, 4'd15, 1'b1}) begin
         failures++;
         $display("FAIL hold_ignores_step got y=%h idx=%0d v=%b exp y=8000 idx=15 v=1", b4.y, b4.idx, b4.valid);
      end
      b4.clear = 1;
      tick();
      b4.clear = 0;
      checks++;
      if ({b4.y, b4.idx, b4.valid} !== {16'h0000, 4'd15, 1'b0}) begin
         failures++;
         $display("FAIL hold_clear got y=%h idx=%0d v=%b exp y=0000 idx=15 v=0", b4.y, b4.idx, b4.valid);
      end
   endtask

   task automatic test_scan_up();
      logic [3:0]  e_idx [3] = '{4'd15, 4'd0, 4'd1};
      logic [15:0] e_y   [3] = '{16'h8000, 16'h0001, 16'h0002};
      logic        e_w   [3] = '{1'b0, 1'b1, 1'b0};
      b4.scan_start = 1; b4.sel = 4'd14;
      tick();
      b4.scan_start = 0;
      checks++;
      if ({b4.y, b4.idx, b4.valid, b4.wrap} !== {16'h4000, 4'd14, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL scan_up_start got y=%h idx=%0d v=%b w=%b exp y=4000 idx=14 v=1 w=0", b4.y, b4.idx, b4.valid, b4.wrap);
      end
      b4.step = 1; b4.dir = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({b4.y, b4.idx, b4.valid, b4.wrap} !== {e_y[i], e_idx[i], 1'b1, e_w[i]}) begin
            failures++;
            $display("FAIL scan_up_step%0d got y=%h idx=%0d w=%b exp y=%h idx=%0d w=%b", i, b4.y, b4.idx, b4.wrap, e_y[i], e_idx[i], e_w[i]);
         end
      end
      b4.step = 0;
   endtask

   task automatic test_scan_down();
      b4.scan_start = 1; b4.sel = 4'd1;
      tick();
      b4.scan_start = 0;
      b4.step = 1; b4.dir = 1;
      tick();
      checks++;
      if ({b4.y, b4.idx, b4.wrap} !== {16'h0001, 4'd0, 1'b0}) begin
         failures++;
         $display("FAIL scan_dn_to0 got y=%h idx=%0d w=%b exp y=0001 idx=0 w=0", b4.y, b4.idx, b4.wrap);
      end
      tick();
      checks++;
      if ({b4.y, b4.idx, b4.wrap} !== {16'h8000, 4'd15, 1'b1}) begin
         failures++;
         $display("FAIL scan_dn_wrap got y=%h idx=%0d w=%b exp y=8000 idx=15 w=1", b4.y, b4.idx, b4.wrap);
      end
      b4.step = 0;
      tick();
      checks++;
      if ({b4.idx, b4.valid, b4.wrap} !== {4'd15, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL scan_dn_pulse_end got idx=%0d v=%b w=%b exp idx=15 v=1 w=0", b4.idx, b4.valid, b4.wrap);
      end
      b4.dir = 0;
   endtask

   task automatic test_priority();
      // SCAN at idx 15: clear+load+step -> IDLE, idx retained
      b4.clear = 1; b4.load = 1; b4.step = 1; b4.sel = 4'd3;
      tick();
      b4.clear = 0; b4.load = 0; b4.step = 0;
      checks++;
      if ({b4.y, b4.idx, b4.valid, b4.wrap} !== {16'h0000, 4'd15, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL prio_clear got y=%h idx=%0d v=%b w=%b exp y=0000 idx=15 v=0 w=0", b4.y, b4.idx, b4.valid, b4.wrap);
      end
      b4.scan_start = 1; b4.sel = 4'd7;
      tick();
      b4.scan_start = 0;
      b4.load = 1; b4.step = 1; b4.sel = 4'd3;
      tick();
      b4.load = 0;
      checks++;
      if ({b4.y, b4.idx, b4.valid} !== {16'h0008, 4'd3, 1'b1}) begin
         failures++;
         $display("FAIL prio_load got y=%h idx=%0d v=%b exp y=0008 idx=3 v=1", b4.y, b4.idx, b4.valid);
      end
      tick();
      checks++;
      if ({b4.y, b4.idx} !== {16'h0008, 4'd3}) begin
         failures++;
         $display("FAIL prio_hold_step got y=%h idx=%0d exp y=0008 idx=3", b4.y, b4.idx);
      end
      // reload from 15 to 0 while step pending: no step, no wrap
      b4.scan_start = 1; b4.sel = 4'd15;
      tick();
      b4.sel = 4'd0;
      tick();
      b4.scan_start = 0; b4.step = 0;
      checks++;
      if ({b4.y, b4.idx, b4.valid, b4.wrap} !== {16'h0001, 4'd0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL reload_no_wrap got y=%h idx=%0d v=%b w=%b exp y=0001 idx=0 v=1 w=0", b4.y, b4.idx, b4.valid, b4.wrap);
      end
   endtask

   task automatic test_async_reset();
      b4.scan_start = 1; b4.sel = 4'd9;
      tick();
      b4.scan_start = 0;
      b4.step = 1;
      checks++;
      if ({b4.y, b4.idx, b4.valid} !== {16'h0200, 4'd9, 1'b1}) begin
         failures++;
         $display("FAIL pre_rst_scan got y=%h idx=%0d v=%b exp y=0200 idx=9 v=1", b4.y, b4.idx, b4.valid);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({b4.y, b4.idx, b4.valid, b4.wrap} !== {16'h0000, 4'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL async_rst got y=%h idx=%0d v=%b w=%b exp y=0000 idx=0 v=0 w=0", b4.y, b4.idx, b4.valid, b4.wrap);
      end
      checks++;
      if ({b4i.y, b4i.idx, b4i.valid} !== {16'hFFFF, 4'd3, 1'b0}) begin
         failures++;
         $display("FAIL async_rst_inv got y=%h idx=%0d v=%b exp y=ffff idx=3 v=0", b4i.y, b4i.idx, b4i.valid);
      end
      @(negedge clk) rst = 1'b0;
      tick();
      b4.step = 0;
      checks++;
      if ({b4.y, b4.idx, b4.valid} !== {16'h0000, 4'd0, 1'b0}) begin
         failures++;
         $display("FAIL post_rst_step got y=%h idx=%0d v=%b exp y=0000 idx=0 v=0", b4.y, b4.idx, b4.valid);
      end
   endtask

   task automatic test_sweep();
      logic [3:0]  one4  = 4'd1;
      logic [31:0] one32 = 32'd1;
      int          k;
      for (int i = 0; i < 4; i++) begin
         b2.load = 1; b2.sel = i[1:0];
         tick();
         checks++;
         if ({b2.y, b2.idx, b2.valid} !== {one4 << i, i[1:0], 1'b1}) begin
            failures++;
            $display("FAIL sweep2_idx%0d got y=%b idx=%0d v=%b exp y=%b", i, b2.y, b2.idx, b2.valid, one4 << i);
         end
      end
      b2.load = 0;
      b5.scan_start = 1; b5.sel = 5'd0;
      tick();
      b5.scan_start = 0;
      b5.step = 1; b5.dir = 0;
      for (int i = 1; i <= 32; i++) begin
         tick();
         k = i % 32;
         checks++;
         if ({b5.y, b5.idx, b5.valid, b5.wrap} !== {one32 << k, k[4:0], 1'b1, (i == 32)}) begin
            failures++;
            $display("FAIL sweep5_step%0d got y=%h idx=%0d w=%b exp y=%h idx=%0d w=%b", i, b5.y, b5.idx, b5.wrap, one32 << k, k, (i == 32));
         end
      end
      b5.step = 0;
   endtask

   initial begin
      test_reset();
      test_load();
      test_scan_up();
      test_scan_down();
      test_priority();
      test_async_reset();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
